piece_bag: RTL and testbench

PIECE_BAG -- requirements
Module: piece_bag

---
 rtl/tetris_pkg.sv | 46 ++++
 rtl/lfsr16.sv | 35 +++
 rtl/piece_bag.sv | 172 +++++++++++++++++
 tb/tb_piece_bag.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: piece codes, board size, draw-FSM states and
// bag helpers used by piece_bag and lfsr16.
package tetris_pkg;

   typedef enum logic [2:0] {
      PC_BLANK    = 3'd0,
      PC_LEN      = 3'd1,
      PC_SKEW     = 3'd2,
      PC_T        = 3'd3,
      PC_L        = 3'd4,
      PC_BLOCK    = 3'd5,
      PC_SKEWEN   = 3'd6,
      PC_STRAIGHT = 3'd7
   } piece_e;

   localparam int BOARD_WIDTH  = 10;
   localparam int BOARD_HEIGHT = 20;
   localparam int NUM_TYPES    = 7;

   localparam logic [6:0]  FULL_MASK = 7'h7F;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAW  = 2'd1,
      ST_FORCE = 2'd2
   } draw_state_e;

   function automatic logic [2:0] popcount7(input logic [6:0] m);
      logic [2:0] n;
      n = '0;
      for (int i = 0; i < NUM_TYPES; i++) n = n + {2'b00, m[i]};
      return n;
   endfunction

   // Lowest code whose mask bit is still set; BLANK for an empty mask.
   function automatic logic [2:0] lowest_code(input logic [6:0] m);
      logic [2:0] c;
      c = PC_BLANK;
      for (int i = NUM_TYPES - 1; i >= 0; i--) begin
         if (m[i]) c = 3'(i + 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR (taps 16'hB400), advances every clock; optional load
// port replaces the next value with a seed (zero seed maps to 16'h0001).
module lfsr16
   import tetris_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        load_i,
   input  logic [15:0] seed_i,
   output logic [15:0] state_o
);

   // An all-zero state would lock the LFSR up forever.
   localparam logic [15:0] RESET_VAL = (SEED == 16'h0000) ? 16'h0001 : SEED;

   logic [15:0] state_q, state_d;

   always_comb begin
      state_d = {1'b0, state_q[15:1]};
      if (state_q[0]) state_d = state_d ^ LFSR_TAPS;
      if (load_i) state_d = (seed_i == 16'h0000) ? 16'h0001 : seed_i;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= RESET_VAL;
      else          state_q <= state_d;
   end

   assign state_o = state_q;

endmodule

// File: rtl/piece_bag.sv
// 7-bag piece randomiser with a preview FIFO. Optional reseed ports are
// enabled by defining PIECE_BAG_RESEED_EN.
module piece_bag
   import tetris_pkg::*;
#(
   parameter int          PREVIEW_DEPTH = 3,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       req,
`ifdef PIECE_BAG_RESEED_EN
   input  logic                       seed_load,
   input  logic [15:0]                seed,
`endif
   output logic [2:0]                 piece,
   output logic                       piece_valid,
   output logic [3*PREVIEW_DEPTH-1:0] preview,
   output logic [2:0]                 bag_left
);

   localparam int SLOTS = PREVIEW_DEPTH + 1;
   localparam int CNT_W = $clog2(SLOTS + 1);
   localparam logic [CNT_W-1:0] SLOTS_C = CNT_W'(SLOTS);

   logic             reseed;
   logic [15:0]      reseed_val;
   logic [15:0]      lfsr_state;
   logic             unused_lfsr_bits;

   draw_state_e      state_q, state_d;
   logic [2:0]       retry_q, retry_d;
   logic [6:0]       mask_q, mask_d;
   logic [2:0]       bag_left_q, bag_left_d;
   logic [2:0]       slot_q [SLOTS];
   logic [2:0]       slot_d [SLOTS];
   logic [CNT_W-1:0] count_q, count_d, count_pop;

   logic             pop;
   logic             push;
   logic [2:0]       push_code;
   logic [2:0]       candidate;
   logic [7:0]       avail8;
   logic             cand_ok;

`ifdef PIECE_BAG_RESEED_EN
   assign reseed     = seed_load;
   assign reseed_val = seed;
`else
   assign reseed     = 1'b0;
   assign reseed_val = 16'h0000;
`endif

   lfsr16 #(
      .SEED    (LFSR_SEED)
   ) u_lfsr (
      .clock   (clock),
      .reset_n (reset_n),
      .load_i  (reseed),
      .seed_i  (reseed_val),
      .state_o (lfsr_state)
   );

   assign unused_lfsr_bits = ^lfsr_state[15:3];

   assign candidate = lfsr_state[2:0];
   assign avail8    = {mask_q, 1'b0};
   assign cand_ok   = avail8[candidate];

   // A request against an empty queue is dropped, and reseed wins over pop.
   assign pop       = req && (count_q != '0) && !reseed;
   assign count_pop = count_q - {{(CNT_W-1){1'b0}}, pop};

   // NOTE: every output of a combinational block gets a default first so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      retry_d   = retry_q;
      push      = 1'b0;
      push_code = PC_BLANK;
      case (state_q)
         ST_IDLE: begin
            if (count_pop < SLOTS_C) state_d = ST_DRAW;
         end
         ST_DRAW: begin
            if (cand_ok) begin
               push      = 1'b1;
               push_code = candidate;
               retry_d   = '0;
               state_d   = ST_IDLE;
            end else begin
               retry_d = retry_q + 3'd1;
               if (retry_q == 3'd6) state_d = ST_FORCE;
            end
         end
         ST_FORCE: begin
            push      = 1'b1;
            push_code = lowest_code(mask_q);
            retry_d   = '0;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (reseed) begin
         state_d = ST_IDLE;
         retry_d = '0;
         push    = 1'b0;
      end
   end

   // Shift-down FIFO: vacated slots refill with BLANK so the outputs can be
   // driven straight from the slots.
   always_comb begin
      for (int i = 0; i < SLOTS; i++) slot_d[i] = slot_q[i];
      if (pop) begin
         for (int i = 0; i < SLOTS - 1; i++) slot_d[i] = slot_q[i+1];
         slot_d[SLOTS-1] = PC_BLANK;
      end
      for (int i = 0; i < SLOTS; i++) begin
         if (push && (count_pop == CNT_W'(i))) slot_d[i] = push_code;
      end
      count_d = count_pop + {{(CNT_W-1){1'b0}}, push};
      if (reseed) begin
         for (int i = 0; i < SLOTS; i++) slot_d[i] = PC_BLANK;
         count_d = '0;
      end
   end

   always_comb begin
      mask_d = mask_q;
      for (int i = 0; i < NUM_TYPES; i++) begin
         if (push && (push_code == 3'(i + 1))) mask_d[i] = 1'b0;
      end
      if (mask_d == 7'h00 || reseed) mask_d = FULL_MASK;
      bag_left_d = popcount7(mask_d);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         retry_q <= '0;
      end else begin
         state_q <= state_d;
         retry_q <= retry_d;
      end
   end

   // NOTE: the slot storage is reset, unlike a plain RAM, because piece and
   // preview must read BLANK from the moment reset asserts.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SLOTS; i++) slot_q[i] <= PC_BLANK;
         count_q    <= '0;
         mask_q     <= FULL_MASK;
         bag_left_q <= 3'd7;
      end else begin
         for (int i = 0; i < SLOTS; i++) slot_q[i] <= slot_d[i];
         count_q    <= count_d;
         mask_q     <= mask_d;
         bag_left_q <= bag_left_d;
      end
   end

   assign piece       = slot_q[0];
   assign piece_valid = (count_q != '0);
   assign bag_left    = bag_left_q;

   for (genvar g = 0; g < PREVIEW_DEPTH; g++) begin : g_preview
      assign preview[3*g +: 3] = slot_q[g+1];
   end

endmodule

// File: tb/tb_piece_bag.sv
// Self-checking bench for piece_bag: cold-start vector table, directed pop
// and reset sequences, bag permutation run, and random traffic vs a model.
module tb_piece_bag;
   import tetris_pkg::*;

   localparam int D     = 3;
   localparam int SLOTS = D + 1;

   logic           clock   = 1'b0;
   logic           reset_n = 1'b0;
   logic           req     = 1'b0;
`ifdef PIECE_BAG_RESEED_EN
   logic           seed_load = 1'b0;
   logic [15:0]    seed      = 16'h0000;
`endif
   logic [2:0]     piece;
   logic           piece_valid;
   logic [3*D-1:0] preview;
   logic [2:0]     bag_left;

   int tests = 0;
   int fails = 0;

   always #5 clock = ~clock;

   piece_bag #(
      .PREVIEW_DEPTH (D),
      .LFSR_SEED     (16'hACE1)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .req         (req),
`ifdef PIECE_BAG_RESEED_EN
      .seed_load   (seed_load),
      .seed        (seed),
`endif
      .piece       (piece),
      .piece_valid (piece_valid),
      .preview     (preview),
      .bag_left    (bag_left)
   );

   // ---------------- reference model ----------------
   // Queue of drawn pieces, set of remaining bag types, and the index of
   // the draw attempt due this cycle (0 none, 1..7 random tries, 8 forced).
   logic [15:0] m_lfsr;
   logic [2:0]  m_q[$];
   bit          m_avail [1:7];
   int          m_attempt;
   int          m_forces = 0;

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
   endfunction

   task automatic model_refill();
      for (int c = 1; c <= 7; c++) m_avail[c] = 1'b1;
   endtask

   task automatic model_reset();
      m_lfsr = 16'hACE1;
      m_q.delete();
      model_refill();
      m_attempt = 0;
   endtask

   task automatic model_step(input bit r, input bit ld, input logic [15:0] sd);
      bit do_pop;
      int pushed;
      int left;
      int ci;
      if (ld) begin
         m_lfsr = (sd == 16'h0000) ? 16'h0001 : sd;
         m_q.delete();
         model_refill();
         m_attempt = 0;
         return;
      end
      do_pop = r && (m_q.size() > 0);
      pushed = 0;
      if (m_attempt == 0) begin
         if (m_q.size() - int'(do_pop) < SLOTS) m_attempt = 1;
      end else if (m_attempt <= 7) begin
         ci = int'(m_lfsr[2:0]);
         if (ci != 0 && m_avail[ci]) pushed = ci;
         else m_attempt++;
      end else begin
         for (int c = 7; c >= 1; c--) if (m_avail[c]) pushed = c;
         m_forces++;
      end
      if (do_pop) void'(m_q.pop_front());
      if (pushed != 0) begin
         m_q.push_back(3'(pushed));
         m_avail[pushed] = 1'b0;
         m_attempt = 0;
         left = 0;
         for (int c = 1; c <= 7; c++) if (m_avail[c]) left++;
         if (left == 0) model_refill();
      end
      m_lfsr = lfsr_next(m_lfsr);
   endtask

   function automatic logic [15:0] model_outputs();
      logic [2:0]     p;
      logic           v;
      logic [3*D-1:0] pv;
      int             b;
      p  = (m_q.size() > 0) ? m_q[0] : 3'd0;
      v  = (m_q.size() > 0);
      pv = '0;
      for (int i = 0; i < D; i++) if (i + 1 < m_q.size()) pv[3*i +: 3] = m_q[i+1];
      b = 0;
      for (int c = 1; c <= 7; c++) if (m_avail[c]) b++;
      return {p, v, pv, 3'(b)};
   endfunction

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] dut_outputs();
      return {piece, piece_valid, preview, bag_left};
   endfunction

   // Drive inputs, take one edge in DUT and model, compare 1 unit later.
   task automatic tick(input bit r, input bit ld, input logic [15:0] sd);
      req = r;
`ifdef PIECE_BAG_RESEED_EN
      seed_load = ld;
      seed      = sd;
`endif
      @(posedge clock);
      model_step(r, ld, sd);
      #1;
      check("model", 32'(dut_outputs()), 32'(model_outputs()));
`ifdef PIECE_BAG_RESEED_EN
      seed_load = 1'b0;
`endif
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      req     = 1'b0;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      check("reset_outputs", 32'(dut_outputs()), 32'({3'd0, 1'b0, 9'd0, 3'd7}));
      check("reset_lfsr", 32'(dut.u_lfsr.state_o), 32'h0000ACE1);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   // Cold-start vectors after reset release with seed 16'hACE1.
   typedef struct {
      bit             req;
      logic [2:0]     piece;
      logic           valid;
      logic [3*D-1:0] preview;
      logic [2:0]     bag;
   } vec_t;

   vec_t cold [10];

   task automatic run_cold_table(input string tag);
      for (int i = 0; i < 10; i++) begin
         tick(cold[i].req, 1'b0, 16'h0000);
         check($sformatf("%s_k%0d", tag, i + 1), 32'(dut_outputs()),
               32'({cold[i].piece, cold[i].valid, cold[i].preview, cold[i].bag}));
      end
   endtask

   logic [2:0] popped[$];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  waited;
      int  budget;
      int  density;
      bit  ok;
      bit  seen [1:7];

      cold[0] = '{1'b1, 3'd0, 1'b0, 9'h000, 3'd7};
      cold[1] = '{1'b1, 3'd0, 1'b0, 9'h000, 3'd7};
      cold[2] = '{1'b1, 3'd0, 1'b0, 9'h000, 3'd7};
      cold[3] = '{1'b0, 3'd4, 1'b1, 9'h000, 3'd6};
      cold[4] = '{1'b0, 3'd4, 1'b1, 9'h000, 3'd6};
      cold[5] = '{1'b0, 3'd4, 1'b1, 9'h007, 3'd5};
      cold[6] = '{1'b0, 3'd4, 1'b1, 9'h007, 3'd5};
      cold[7] = '{1'b0, 3'd4, 1'b1, 9'h00F, 3'd4};
      cold[8] = '{1'b0, 3'd4, 1'b1, 9'h00F, 3'd4};
      cold[9] = '{1'b0, 3'd4, 1'b1, 9'h08F, 3'd3};

      // Cold start; requests against the empty queue must be ignored.
      do_reset();
      run_cold_table("cold");
      tick(1'b0, 1'b0, 16'h0000);
      tick(1'b0, 1'b0, 16'h0000);
      check("full_steady", 32'(dut_outputs()), 32'({3'd4, 1'b1, 9'h08F, 3'd3}));

      // One-cycle pop of a full queue: head shifts, refill lands last.
      tick(1'b1, 1'b0, 16'h0000);
      check("pop_shift", 32'({piece, piece_valid, preview}), 32'({3'd7, 1'b1, 9'h011}));
      waited = 0;
      while (preview[8:6] == 3'd0 && waited < 10) begin
         tick(1'b0, 1'b0, 16'h0000);
         waited++;
      end
      check("refill_in_time", 32'(waited <= 8), 32'd1);
      check("refill_keep", 32'({piece, preview[5:0]}), 32'({3'd7, 6'o21}));

      // Reset mid-draw (right after a pop started a draw).
      tick(1'b1, 1'b0, 16'h0000);
      reset_n = 1'b0;
      #1;
      check("async_reset", 32'(dut_outputs()), 32'({3'd0, 1'b0, 9'd0, 3'd7}));
      req = 1'b0;
      model_reset();
      @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      run_cold_table("rerun");

      // Hold req until 70 pieces popped: ten full bags.
      do_reset();
      popped.delete();
      budget = 0;
      while (popped.size() < 70 && budget < 1000) begin
         if (piece_valid) popped.push_back(piece);
         tick(1'b1, 1'b0, 16'h0000);
         budget++;
      end
      check("pop_count", 32'(popped.size()), 32'd70);
      for (int g = 0; g < popped.size() / 7; g++) begin
         ok = 1'b1;
         for (int c = 1; c <= 7; c++) seen[c] = 1'b0;
         for (int k = 0; k < 7; k++) begin
            if (popped[7*g+k] == 3'd0 || seen[popped[7*g+k]]) ok = 1'b0;
            else seen[popped[7*g+k]] = 1'b1;
         end
         check($sformatf("bag_perm_%0d", g), 32'(ok), 32'd1);
      end

`ifdef PIECE_BAG_RESEED_EN
      // Reseed with zero while requesting: no pop, queue empties, LFSR=1.
      tick(1'b1, 1'b1, 16'h0000);
      check("reseed_empty", 32'(piece_valid), 32'd0);
      check("reseed_lfsr", 32'(dut.u_lfsr.state_o), 32'h00000001);
      for (int i = 0; i < 30; i++) tick(1'(i % 3 == 0), 1'b0, 16'h0000);
      tick(1'b1, 1'b1, 16'h0000);
      check("reseed_again", 32'(dut.u_lfsr.state_o), 32'h00000001);
      for (int i = 0; i < 30; i++) tick(1'(i % 3 == 0), 1'b0, 16'h0000);
`endif

      // Random traffic with varying request density.
      density = 50;
      for (int n = 0; n < 3000; n++) begin
         bit          r;
         bit          ld;
         logic [15:0] sd;
         if (n % 200 == 0) density = (n / 200) % 3 == 0 ? 10 : ((n / 200) % 3 == 1 ? 50 : 90);
         r  = ($urandom_range(0, 99) < density);
         ld = 1'b0;
         sd = 16'h0000;
`ifdef PIECE_BAG_RESEED_EN
         ld = ($urandom_range(0, 199) == 0);
         sd = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
`endif
         tick(r, ld, sd);
      end
      check("force_seen", 32'(m_forces > 0), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
